// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak state width and arbiter FSM encoding.
// Rev 1.0
`default_nettype none

package keccak_pkg;

  localparam int KECCAK_STATE_W = 1600;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/keccak_arb_pick.sv
// keccak_arb_pick: 2-way grant selection; round-robin when KECCAK_ARB_RR_EN is defined.
// Rev 1.0
`default_nettype none

module keccak_arb_pick (
  input  logic [1:0] valids,
  input  logic       last_owner,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |valids;

`ifdef KECCAK_ARB_RR_EN
  // A tie goes to whichever requester did not win last time.
  always_comb begin
    grant_idx = valids[1] & ~valids[0];
    if (valids == 2'b11) begin
      grant_idx = ~last_owner;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign grant_idx         = valids[1] & ~valids[0];
`endif

endmodule

`default_nettype wire

// File: rtl/keccak_perm_arbiter.sv
// keccak_perm_arbiter: shares one KeccakF1600 engine between two requesters (KECCAK_ARB_RR_EN selects round-robin).
// Rev 1.0
`default_nettype none

module keccak_perm_arbiter
  import keccak_pkg::*;
#(
  parameter int STATE_W = KECCAK_STATE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic               req1_valid,
  input  logic [STATE_W-1:0] req0_state,
  input  logic [STATE_W-1:0] req1_state,
  output logic               req0_done,
  output logic               req1_done,
  output logic [STATE_W-1:0] result_state,
  output logic               perm_start,
  output logic [STATE_W-1:0] perm_state_in,
  input  logic [STATE_W-1:0] perm_state_out,
  input  logic               perm_done,
  output logic               busy,
  output logic               owner,
  output logic               spurious_done,
  output logic [1:0]         debug_arb_state
);

  arb_state_t state;
  arb_state_t state_next;
  logic       grant_valid;
  logic       grant_idx;
  logic       last_owner;
  logic       grant_take;

  keccak_arb_pick u_pick (
    .valids      ({req1_valid, req0_valid}),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign grant_take = (state == ARB_IDLE) && grant_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    perm_start = 1'b0;
    req0_done  = 1'b0;
    req1_done  = 1'b0;
    busy       = 1'b1;
    case (state)
      ARB_IDLE: begin
        busy = 1'b0;
        if (grant_valid) begin
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        perm_start = 1'b1;
        state_next = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (perm_done) begin
          state_next = ARB_RESP;
        end
      end
      ARB_RESP: begin
        req0_done  = ~owner;
        req1_done  = owner;
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Engine completions arriving outside WAIT never touch data; they only flag an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner         <= 1'b0;
      perm_state_in <= '0;
      result_state  <= '0;
      spurious_done <= 1'b0;
    end else begin
      if (grant_take) begin
        owner         <= grant_idx;
        perm_state_in <= grant_idx ? req1_state : req0_state;
      end
      if (perm_done) begin
        if (state == ARB_WAIT) begin
          result_state <= perm_state_out;
        end else begin
          spurious_done <= 1'b1;
        end
      end
    end
  end

`ifdef KECCAK_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if (grant_take) begin
      last_owner <= grant_idx;
    end
  end
`else
  assign last_owner = 1'b1;
`endif

  assign debug_arb_state = state;

endmodule

`default_nettype wire
